pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
Transmit-side counterpart of edge_detector: converts a single-cycle start request into a programmable train of level pulses on `signal`. Each pulse produces exactly one rising edge for a downstream edge_detector. Used as a stimulus/handshake source: a config-driven waveform generator with busy/done status.

Parameters:
LEN_W, 8, width of high_len / low_len phase-length fields (cycles)
NUM_W, 8, width of num_pulses and pulse_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
high_len  input  LEN_W  cycles signal stays high per pulse; latched on accepted start
low_len  input  LEN_W  cycles signal stays low between pulses; latched on accepted start
num_pulses  input  NUM_W  pulses to emit; latched on accepted start
abort  input  1  terminate train immediately
signal  output  1  generated waveform (registered)
busy  output  1  train in progress
done  output  1  one-cycle pulse on normal completion
pulse_cnt  output  NUM_W  pulses completed in current/last train

Behaviour:
- Reset (sync, checked first, overrides everything): signal=0, busy=0, done=0, pulse_cnt=0, FSM=IDLE, latched config cleared.
- FSM states: IDLE, HIGH, LOW. All outputs registered.
- IDLE: start=1, abort=0, num_pulses!=0, high_len!=0 at edge k -> latch H=high_len, L=max(low_len,1), N=num_pulses; pulse_cnt<=0; signal<=1, busy<=1 at edge k; -> HIGH, phase counter loaded.
- Degenerate start in IDLE (num_pulses==0 or high_len==0): no pulse; done<=1 for one cycle, pulse_cnt<=0, busy stays 0.
- HIGH: signal=1 for exactly H cycles (edge k .. edge k+H). At end of phase pulse_cnt<=pulse_cnt+1.
  - pulses remaining -> signal<=0, -> LOW.
  - last pulse -> signal<=0, busy<=0, done<=1 (same edge), -> IDLE.
- LOW: signal=0 for exactly L cycles, then signal<=1, -> HIGH. low_len=0 treated as 1 so consecutive pulses always have a distinct rising edge.
- Rising-edge n (n=0..N-1) of signal occurs at edge k+n*(H+L); final falling edge at k+N*H+(N-1)*L.
- done is high exactly one cycle; cleared on the following edge regardless of other inputs.
- start while busy=1: ignored, latched config unchanged.
- start in the cycle done=1: accepted (FSM already IDLE).
- abort while busy: next edge signal<=0, busy<=0, done stays 0, pulse_cnt holds completed count (partial high phase not counted), -> IDLE.
- abort and start same cycle in IDLE: abort wins, start ignored.
- Inputs high_len/low_len/num_pulses may change freely while busy; no effect until next accepted start.
- Counters sized LEN_W/NUM_W; max values (2^W-1) supported without wrap. pulse_cnt never exceeds N.

Test Plan:
- Reset 2 cycles, start at edge 3 with H=3,N=1 -> signal high edges 3..6, done=1 cycle after edge 6, busy high edges 3..6, pulse_cnt=1; edge_detector on signal gives 1 pos_edge.
- H=2,L=2,N=3, start at edge 10 -> rising edges at 10,14,18; final fall at 20 with done; pulse_cnt=3; downstream pos_edge count=3.
- H=1,L=0,N=4 -> L forced to 1: signal 1010101 then 0, four rising edges, done at edge 7 after start.
- num_pulses=0 (and separately high_len=0) -> signal stays 0, busy stays 0, done pulses once next cycle, pulse_cnt=0.
- Start H=4,L=4,N=5; re-assert start with different config mid-train -> ignored; abort during 3rd HIGH -> signal 0 next edge, busy 0, done 0, pulse_cnt=2.
- Reset asserted during LOW phase of a train -> next edge all outputs 0, FSM IDLE; subsequent start runs a fresh train correctly.

Source files
------------

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable pulse train generator with busy/done status
module pulse_train_gen #(
    parameter int LEN_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    input  logic             abort,
    output logic             signal,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             signal_q, signal_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [LEN_W-1:0] h_q, h_d;
    logic [LEN_W-1:0] l_q, l_d;
    logic [NUM_W-1:0] n_q, n_d;
    // phase_q counts the cycles left in the current phase minus one
    logic [LEN_W-1:0] phase_q, phase_d;
    logic [NUM_W-1:0] pulse_cnt_inc;

    assign pulse_cnt_inc = pulse_cnt_q + NUM_ONE;

    // Next-state and registered-output computation; done is a one-cycle strobe
    always_comb begin
        state_d     = state_q;
        signal_d    = signal_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pulse_cnt_d = pulse_cnt_q;
        h_d         = h_q;
        l_d         = l_q;
        n_d         = n_q;
        phase_d     = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (num_pulses == '0 || high_len == '0) begin
                        done_d      = 1'b1;
                        pulse_cnt_d = '0;
                    end else begin
                        h_d         = high_len;
                        // A zero low phase would merge pulses; stretch it to one cycle
                        l_d         = (low_len == '0) ? LEN_ONE : low_len;
                        n_d         = num_pulses;
                        pulse_cnt_d = '0;
                        signal_d    = 1'b1;
                        busy_d      = 1'b1;
                        phase_d     = high_len - LEN_ONE;
                        state_d     = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    signal_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (phase_q == '0) begin
                    pulse_cnt_d = pulse_cnt_inc;
                    signal_d    = 1'b0;
                    if (pulse_cnt_inc == n_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        phase_d = l_q - LEN_ONE;
                        state_d = ST_LOW;
                    end
                end else begin
                    phase_d = phase_q - LEN_ONE;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    signal_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (phase_q == '0) begin
                    signal_d = 1'b1;
                    phase_d  = h_q - LEN_ONE;
                    state_d  = ST_HIGH;
                end else begin
                    phase_d = phase_q - LEN_ONE;
                end
            end
            default: begin
                signal_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            signal_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pulse_cnt_q <= '0;
            h_q         <= '0;
            l_q         <= '0;
            n_q         <= '0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            signal_q    <= signal_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pulse_cnt_q <= pulse_cnt_d;
            h_q         <= h_d;
            l_q         <= l_d;
            n_q         <= n_d;
            phase_q     <= phase_d;
        end
    end

    assign signal    = signal_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - self-checking bench for pulse_train_gen
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] high_len = '0;
    logic [7:0] low_len = '0;
    logic [7:0] num_pulses = '0;
    logic       signal;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    pulse_train_gen #(.LEN_W(8), .NUM_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .high_len(high_len),
        .low_len(low_len), .num_pulses(num_pulses), .abort(abort),
        .signal(signal), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int rises = 0;
    logic prev_sig = 1'b0;

    // Reference model: position j in the train since the accepting edge
    bit m_active, m_sig, m_busy, m_done;
    int m_j, m_H, m_L, m_N, m_cnt;

    function automatic int completed(input int j, input int h, input int l, input int n);
        int c;
        if (j < h) return 0;
        c = (j - h) / (h + l) + 1;
        return (c > n) ? n : c;
    endfunction

    task automatic model_update(input bit r, input bit s, input bit a,
                                input int h, input int l, input int n);
        if (r) begin
            m_active = 0; m_sig = 0; m_busy = 0; m_done = 0;
            m_cnt = 0; m_j = 0; m_H = 0; m_L = 0; m_N = 0;
        end else if (m_active) begin
            m_done = 0;
            if (a) begin
                m_active = 0; m_sig = 0; m_busy = 0;
            end else begin
                m_j++;
                if (m_j == m_N * m_H + (m_N - 1) * m_L) begin
                    m_active = 0; m_sig = 0; m_busy = 0; m_done = 1; m_cnt = m_N;
                end else begin
                    m_sig = (m_j % (m_H + m_L)) < m_H;
                    m_cnt = completed(m_j, m_H, m_L, m_N);
                end
            end
        end else begin
            m_done = 0;
            if (s && !a) begin
                if (n == 0 || h == 0) begin
                    m_done = 1; m_cnt = 0;
                end else begin
                    m_active = 1; m_j = 0; m_H = h; m_L = (l == 0) ? 1 : l; m_N = n;
                    m_sig = 1; m_busy = 1; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge
    task automatic step(input bit r, input bit s, input bit a,
                        input int h, input int l, input int n);
        reset = r; start = s; abort = a;
        high_len = 8'(h); low_len = 8'(l); num_pulses = 8'(n);
        model_update(r, s, a, h, l, n);
        @(posedge clk);
        #1;
        if (signal && !prev_sig) rises++;
        prev_sig = signal;
        vectors++;
        if (signal !== m_sig || busy !== m_busy || done !== m_done || int'(pulse_cnt) != m_cnt) begin
            miscompares++;
            $display("FAIL model at %0t: sig/busy/done/cnt got %0b/%0b/%0b/%0d expected %0b/%0b/%0b/%0d",
                     $time, signal, busy, done, pulse_cnt, m_sig, m_busy, m_done, m_cnt);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit r, s, a;
        int h, l, n;
        bit e_sig, e_busy, e_done;
        int e_cnt;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1,0,0, 0,0,0, 0,0,0,0};
        tbl[1]  = '{1,0,0, 0,0,0, 0,0,0,0};
        tbl[2]  = '{0,1,0, 3,0,1, 1,1,0,0};
        tbl[3]  = '{0,0,0, 0,0,0, 1,1,0,0};
        tbl[4]  = '{0,0,0, 0,0,0, 1,1,0,0};
        tbl[5]  = '{0,0,0, 0,0,0, 0,0,1,1};
        tbl[6]  = '{0,0,0, 0,0,0, 0,0,0,1};
        tbl[7]  = '{0,1,0, 0,3,5, 0,0,1,0};
        tbl[8]  = '{0,1,0, 2,3,0, 0,0,1,0};
        tbl[9]  = '{0,0,0, 0,0,0, 0,0,0,0};
        tbl[10] = '{0,1,1, 1,0,2, 0,0,0,0};
        tbl[11] = '{0,1,0, 1,0,2, 1,1,0,0};
        tbl[12] = '{0,0,0, 0,0,0, 0,1,0,1};
        tbl[13] = '{0,0,0, 0,0,0, 1,1,0,1};
        tbl[14] = '{0,1,0, 9,9,9, 0,0,1,2};
        tbl[15] = '{0,1,0, 1,0,1, 1,1,0,0};
        tbl[16] = '{0,0,0, 0,0,0, 0,0,1,1};
        tbl[17] = '{0,0,0, 0,0,0, 0,0,0,1};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].h, tbl[i].l, tbl[i].n);
            check($sformatf("tbl%0d_sig", i), int'(signal), int'(tbl[i].e_sig));
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
            check($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
            check($sformatf("tbl%0d_cnt", i), int'(pulse_cnt), tbl[i].e_cnt);
        end

        // H=2 L=2 N=3: rising edges at k, k+4, k+8, final fall with done at k+10
        idle(2);
        rises = 0;
        step(0, 1, 0, 2, 2, 3);
        idle(9);
        check("hl22_busy_before_end", int'(busy), 1);
        idle(1);
        check("hl22_done", int'(done), 1);
        check("hl22_cnt", int'(pulse_cnt), 3);
        check("hl22_rises", rises, 3);

        // H=1 L=0 N=4: low phase forced to one cycle, done 7 edges after start
        idle(1);
        rises = 0;
        step(0, 1, 0, 1, 0, 4);
        idle(6);
        check("l0_no_done_yet", int'(done), 0);
        idle(1);
        check("l0_done", int'(done), 1);
        check("l0_rises", rises, 4);

        // H=4 L=4 N=5: mid-train start ignored, abort during third high phase
        idle(1);
        step(0, 1, 0, 4, 4, 5);
        idle(5);
        step(0, 1, 0, 1, 1, 1);
        idle(10);
        check("ab_third_high", int'(signal), 1);
        step(0, 0, 1, 0, 0, 0);
        check("ab_sig", int'(signal), 0);
        check("ab_busy", int'(busy), 0);
        check("ab_done", int'(done), 0);
        check("ab_cnt", int'(pulse_cnt), 2);
        idle(2);
        check("ab_done_later", int'(done), 0);

        // Reset during a low phase, then a fresh train
        step(0, 1, 0, 3, 3, 2);
        idle(4);
        step(1, 0, 0, 0, 0, 0);
        check("rst_sig", int'(signal), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt", int'(pulse_cnt), 0);
        step(0, 1, 0, 2, 1, 2);
        idle(5);
        check("rst_fresh_done", int'(done), 1);
        check("rst_fresh_cnt", int'(pulse_cnt), 2);

        // Maximum field values
        step(0, 1, 0, 255, 255, 2);
        idle(765);
        check("max_len_done", int'(done), 1);
        check("max_len_cnt", int'(pulse_cnt), 2);
        step(0, 1, 0, 1, 1, 255);
        idle(509);
        check("max_num_done", int'(done), 1);
        check("max_num_cnt", int'(pulse_cnt), 255);

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 39) == 0),
                 int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
